// File: rtl/one_hot_serializer_pkg.sv
// Shared types and sizing helpers for the one-hot serializer.
// Used by the interface and the core; no configuration macros here.
package one_hot_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index bus is never narrower than one bit, even for WIDTH == 1.
  function automatic int unsigned index_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/one_hot_serializer_if.sv
// Vector-in / beat-out handshake bundle for one_hot_serializer.
// output_index exists only when ONE_HOT_SERIALIZER_INDEX_EN is defined.
interface one_hot_serializer_if
  import one_hot_serializer_pkg::*;
  #(parameter int unsigned WIDTH = 8);

  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_one_hot;
  logic             output_last;
  logic             output_valid;
  logic             output_ready;

`ifdef ONE_HOT_SERIALIZER_INDEX_EN
  localparam int unsigned INDEX_WIDTH = index_width(WIDTH);
  logic [INDEX_WIDTH-1:0] output_index;

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_one_hot, output_index, output_last, output_valid
  );

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_one_hot, output_index, output_last, output_valid
  );
`else
  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_one_hot, output_last, output_valid
  );

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_one_hot, output_last, output_valid
  );
`endif

endinterface

// File: rtl/one_hot_serializer_first_one.sv
// Isolates the lowest set bit of a vector (all-zero in, all-zero out).
module first_one #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] vector,
  output logic [WIDTH-1:0] one_hot
);

  // Two's-complement trick: x & -x keeps only the least-significant one.
  assign one_hot = vector & (~vector + WIDTH'(1));

endmodule

// File: rtl/one_hot_serializer.sv
// Serializes each set bit of an accepted vector into one-hot beats, LSB first.
// Define ONE_HOT_SERIALIZER_INDEX_EN to add the binary output_index port.
module one_hot_serializer
  import one_hot_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  one_hot_serializer_if.slave  bus,
  output logic                 busy
);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] low_bit;
  logic             single_left;
  logic             valid_q;
  logic             ready_q;
  logic             busy_q;

  first_one #(.WIDTH(WIDTH)) u_first_one (
    .vector  (remaining),
    .one_hot (low_bit)
  );

  // remaining is zero whenever the FSM is IDLE, so every beat output is
  // already zero there; the valid gating only makes that explicit.
  assign single_left = (remaining & ~low_bit) == '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.input_valid && (bus.input_data != '0)) begin
            remaining <= bus.input_data;
            state     <= BUSY;
            valid_q   <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.output_ready) begin
            remaining <= remaining & ~low_bit;
            if (single_left) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          valid_q   <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.input_ready    = ready_q;
  assign bus.output_valid   = valid_q;
  assign bus.output_one_hot = valid_q ? low_bit : '0;
  assign bus.output_last    = valid_q & single_left;
  assign busy               = busy_q;

`ifdef ONE_HOT_SERIALIZER_INDEX_EN
  localparam int unsigned INDEX_WIDTH = index_width(WIDTH);
  logic [INDEX_WIDTH-1:0] index;

  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (low_bit[i]) index = INDEX_WIDTH'(i);
    end
  end

  assign bus.output_index = valid_q ? index : '0;
`endif

  beat_is_one_hot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(bus.output_one_hot));

  valid_has_beat : assert property (@(posedge clock) disable iff (reset)
    bus.output_valid |-> (bus.output_one_hot != '0));

endmodule

// File: tb/tb_one_hot_serializer.sv
// Randomized and scenario-driven bench for one_hot_serializer with a queue-of-bit-positions model.
module tb_one_hot_serializer;

  localparam int unsigned WIDTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  one_hot_serializer_if #(.WIDTH(WIDTH)) bus ();

  one_hot_serializer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Expected beats still to come, as bit positions in emission order.
  int unsigned beats[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = beats.size() > 0;
    check("output_valid",   32'(bus.output_valid),   32'(v));
    check("output_one_hot", 32'(bus.output_one_hot), v ? (32'd1 << beats[0]) : 32'd0);
    check("output_last",    32'(bus.output_last),    32'(v && beats.size() == 1));
    check("input_ready",    32'(bus.input_ready),    32'(!v));
    check("busy",           32'(busy),               32'(v));
`ifdef ONE_HOT_SERIALIZER_INDEX_EN
    check("output_index",   32'(bus.output_index),   v ? 32'(beats[0]) : 32'd0);
`endif
  endtask

  // Check the current cycle, then present inputs for the coming edge.
  task automatic step(input bit in_valid, input logic [WIDTH-1:0] data, input bit out_ready);
    @(negedge clock);
    check_outputs();
    bus.input_valid  = in_valid;
    bus.input_data   = data;
    bus.output_ready = out_ready;
    if (beats.size() > 0) begin
      if (out_ready) void'(beats.pop_front());
    end else if (in_valid) begin
      for (int i = 0; i < int'(WIDTH); i++)
        if (data[i]) beats.push_back(i);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    check_outputs();
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    beats.delete();
    check_outputs();
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;

    #12 check_outputs();
    #1 reset = 1'b0;

    // Three sparse bits with no backpressure.
    step(1'b1, 8'b1010_0100, 1'b1);
    idle(4);

    // Full vector, stall three cycles on the second beat.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    idle(8);

    // Zero vector is dropped; a single-bit vector follows.
    step(1'b1, 8'h00, 1'b1);
    idle(2);
    step(1'b1, 8'h01, 1'b1);
    idle(2);

    // New vector offered while busy must be ignored.
    step(1'b1, 8'h30, 1'b1);
    step(1'b1, 8'h0F, 1'b1);
    step(1'b1, 8'h0F, 1'b1);
    idle(3);

    // Reset after two of three beats abandons the third.
    step(1'b1, 8'h07, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    pulse_reset();
    step(1'b1, 8'h80, 1'b1);
    idle(3);

    // Random traffic with occasional zero vectors and resets.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0)
        pulse_reset();
      else
        step(1'($urandom_range(0, 1)), d, $urandom_range(0, 9) < 7);
    end
    idle(WIDTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
